// File: rtl/time_display_driver_pkg.sv
// Shared constants and types for the seconds-of-day display driver.
package time_disp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SUB_H,
        ST_SUB_M,
        ST_SPLIT,
        ST_COMMIT,
        ST_ERR
    } state_t;

    localparam logic [31:0] SEC_PER_DAY  = 32'd86400;
    localparam logic [16:0] SEC_PER_HOUR = 17'd3600;
    localparam logic [16:0] SEC_PER_MIN  = 17'd60;
    localparam logic [3:0]  DIGIT_DASH   = 4'hF;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/time_display_driver_if.sv
// Signal bundle between the timekeeping side and the display driver.
interface time_display_driver_if;
    logic [31:0] time_in;
    logic        blank;
    logic [6:0]  seg;
    logic        dp;
    logic [5:0]  an;
    logic [23:0] digits_bcd;
    logic        busy;
    logic        range_err;

    modport master (
        output time_in, blank,
        input  seg, dp, an, digits_bcd, busy, range_err
    );

    modport slave (
        input  time_in, blank,
        output seg, dp, an, digits_bcd, busy, range_err
    );
endinterface

// File: rtl/time_display_driver_seg7_decode.sv
// BCD digit to active-high 7-segment pattern; 4'hF shows a dash, A-E blank.
module seg7_decode
    import time_disp_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_digit)
            4'd0:       o_seg = SEG_0;
            4'd1:       o_seg = SEG_1;
            4'd2:       o_seg = SEG_2;
            4'd3:       o_seg = SEG_3;
            4'd4:       o_seg = SEG_4;
            4'd5:       o_seg = SEG_5;
            4'd6:       o_seg = SEG_6;
            4'd7:       o_seg = SEG_7;
            4'd8:       o_seg = SEG_8;
            4'd9:       o_seg = SEG_9;
            DIGIT_DASH: o_seg = SEG_DASH;
            default:    o_seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/time_display_driver.sv
// Converts seconds-of-day to HH.MM.SS BCD by repeated subtraction and scans
// the six digits onto a multiplexed common-anode 7-segment display.
module time_display_driver
    import time_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter bit          SEG_ACT_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    time_display_driver_if.slave bus
);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    state_t      r_state, w_next;
    logic [31:0] r_last;
    logic [16:0] r_rem;
    logic [4:0]  r_h;
    logic [5:0]  r_m;
    logic [3:0]  r_ht, r_mt, r_st;
    logic [1:0]  r_sel;
    logic [23:0] r_digits;
    logic        r_busy, r_range_err;

    logic        w_change, w_range_bad, w_ge_hour, w_ge_min, w_ge10;
    logic [5:0]  w_split_val;

    assign w_change    = (bus.time_in != r_last);
    assign w_range_bad = (bus.time_in >= SEC_PER_DAY);
    assign w_ge_hour   = (r_rem >= SEC_PER_HOUR);
    assign w_ge_min    = (r_rem >= SEC_PER_MIN);

    // SPLIT walks hours, minutes, seconds in turn; seconds live in r_rem
    always_comb begin
        w_split_val = r_rem[5:0];
        case (r_sel)
            2'd0:    w_split_val = {1'b0, r_h};
            2'd1:    w_split_val = r_m;
            default: w_split_val = r_rem[5:0];
        endcase
    end
    assign w_ge10 = (w_split_val >= 6'd10);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_change) w_next = w_range_bad ? ST_ERR : ST_SUB_H;
            ST_SUB_H:  if (!w_ge_hour) w_next = ST_SUB_M;
            ST_SUB_M:  if (!w_ge_min) w_next = ST_SPLIT;
            ST_SPLIT:  if (!w_ge10 && r_sel == 2'd2) w_next = ST_COMMIT;
            ST_COMMIT: w_next = ST_IDLE;
            ST_ERR:    w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last      <= '0;
            r_rem       <= '0;
            r_h         <= '0;
            r_m         <= '0;
            r_ht        <= '0;
            r_mt        <= '0;
            r_st        <= '0;
            r_sel       <= '0;
            r_digits    <= '0;
            r_busy      <= 1'b0;
            r_range_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_change) begin
                    r_last <= bus.time_in;
                    r_rem  <= bus.time_in[16:0];
                    r_h    <= '0;
                    r_m    <= '0;
                    r_ht   <= '0;
                    r_mt   <= '0;
                    r_st   <= '0;
                    r_sel  <= '0;
                    r_busy <= 1'b1;
                end
                ST_SUB_H: if (w_ge_hour) begin
                    r_rem <= r_rem - SEC_PER_HOUR;
                    r_h   <= r_h + 5'd1;
                end
                ST_SUB_M: if (w_ge_min) begin
                    r_rem <= r_rem - SEC_PER_MIN;
                    r_m   <= r_m + 6'd1;
                end
                ST_SPLIT: begin
                    if (w_ge10) begin
                        case (r_sel)
                            2'd0: begin r_h <= r_h - 5'd10; r_ht <= r_ht + 4'd1; end
                            2'd1: begin r_m <= r_m - 6'd10; r_mt <= r_mt + 4'd1; end
                            default: begin r_rem <= r_rem - 17'd10; r_st <= r_st + 4'd1; end
                        endcase
                    end else if (r_sel != 2'd2) begin
                        r_sel <= r_sel + 2'd1;
                    end
                end
                ST_COMMIT: begin
                    r_digits    <= {r_ht, r_h[3:0], r_mt, r_m[3:0], r_st, r_rem[3:0]};
                    r_busy      <= 1'b0;
                    r_range_err <= 1'b0;
                end
                ST_ERR: begin
                    r_digits    <= {6{DIGIT_DASH}};
                    r_busy      <= 1'b0;
                    r_range_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic             w_wrap;
    logic [3:0]       w_digit;
    logic [6:0]       w_seg_hi;
    logic [5:0]       w_an_hi;
    logic             w_dp_hi;
    logic [6:0]       r_seg;
    logic [5:0]       r_an;
    logic             r_dp;

    assign w_wrap = (r_cnt == CNT_W'(REFRESH_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= 3'd5;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_idx <= (r_idx == 3'd0) ? 3'd5 : r_idx - 3'd1;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_digit = r_digits[{r_idx, 2'b00} +: 4];

    seg7_decode u_dec (
        .i_digit (w_digit),
        .o_seg   (w_seg_hi)
    );

    assign w_an_hi = bus.blank ? 6'b0 : (6'b1 << r_idx);
    // Separator dots after HH and MM blink with the seconds ones digit
    assign w_dp_hi = ((r_idx == 3'd4) || (r_idx == 3'd2)) && !r_digits[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg <= {7{SEG_ACT_LOW}};
            r_an  <= {6{SEG_ACT_LOW}};
            r_dp  <= SEG_ACT_LOW;
        end else begin
            r_seg <= w_seg_hi ^ {7{SEG_ACT_LOW}};
            r_an  <= w_an_hi ^ {6{SEG_ACT_LOW}};
            r_dp  <= w_dp_hi ^ SEG_ACT_LOW;
        end
    end

    assign bus.seg        = r_seg;
    assign bus.an         = r_an;
    assign bus.dp         = r_dp;
    assign bus.digits_bcd = r_digits;
    assign bus.busy       = r_busy;
    assign bus.range_err  = r_range_err;
endmodule

// File: tb/tb_time_display_driver.sv
// Directed bench: conversion vectors, range errors, mid-conversion changes,
// async reset and scan/blank/dp timing with a short refresh period.
module tb_time_display_driver;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    time_display_driver_if dif ();

    time_display_driver #(.REFRESH_DIV(4), .SEG_ACT_LOW(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] t;
        logic [23:0] d;
        logic        re;
        logic        scan;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] pat(input logic [3:0] d);
        case (d)
            4'd0: pat = 7'h3F; 4'd1: pat = 7'h06; 4'd2: pat = 7'h5B;
            4'd3: pat = 7'h4F; 4'd4: pat = 7'h66; 4'd5: pat = 7'h6D;
            4'd6: pat = 7'h7D; 4'd7: pat = 7'h07; 4'd8: pat = 7'h7F;
            4'd9: pat = 7'h6F; 4'hF: pat = 7'h40;
            default: pat = 7'h00;
        endcase
    endfunction

    function automatic int lit_idx(input logic [5:0] an_pins);
        int k;
        k = -1;
        for (int i = 0; i < 6; i++)
            if (an_pins == ~(6'b1 << i)) k = i;
        return k;
    endfunction

    task automatic apply(input string tag, input logic [31:0] t,
                         input logic [23:0] d, input logic re);
        int lat;
        dif.time_in = t;
        @(negedge clk);
        chk({tag, "_busy_rise"}, {31'b0, dif.busy}, 32'd1);
        lat = 0;
        while (dif.busy && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency_le110"}, {31'b0, (lat <= 110)}, 32'd1);
        chk({tag, "_digits"}, {8'b0, dif.digits_bcd}, {8'b0, d});
        chk({tag, "_range_err"}, {31'b0, dif.range_err}, {31'b0, re});
    endtask

    task automatic scan_check(input string tag, input logic [23:0] d);
        int          prev_k, k, exp_k;
        logic [5:0]  seen;
        logic [6:0]  exp_seg;
        logic        exp_dp;
        prev_k = -1;
        seen   = '0;
        for (int c = 0; c < 40 && seen != 6'h3F; c++) begin
            @(negedge clk);
            k = lit_idx(dif.an);
            if (k >= 0 && k != prev_k) begin
                if (prev_k >= 0) begin
                    exp_k = (prev_k == 0) ? 5 : prev_k - 1;
                    chk({tag, "_order"}, k, exp_k);
                end
                exp_seg = ~pat(d[k*4 +: 4]);
                exp_dp  = ~(((k == 4) || (k == 2)) && !d[0]);
                chk({tag, "_seg"}, {25'b0, dif.seg}, {25'b0, exp_seg});
                chk({tag, "_dp"}, {31'b0, dif.dp}, {31'b0, exp_dp});
                seen[k] = 1'b1;
                prev_k  = k;
            end
        end
        chk({tag, "_all_digits_seen"}, {26'b0, seen}, 32'h3F);
    endtask

    initial begin
        int         busy_hi, bad, illegal, run, nchg;
        logic [5:0] prev_an;
        logic [23:0] prev_d, first_new;
        bit         started, done;

        vecs[0] = '{32'd45296,  24'h123456, 1'b0, 1'b1};
        vecs[1] = '{32'd45297,  24'h123457, 1'b0, 1'b1};
        vecs[2] = '{32'd86399,  24'h235959, 1'b0, 1'b0};
        vecs[3] = '{32'd86400,  24'hFFFFFF, 1'b1, 1'b1};
        vecs[4] = '{32'd0,      24'h000000, 1'b0, 1'b0};
        vecs[5] = '{32'd3600,   24'h010000, 1'b0, 1'b0};
        vecs[6] = '{32'd59,     24'h000059, 1'b0, 1'b0};
        vecs[7] = '{32'd100000, 24'hFFFFFF, 1'b1, 1'b0};
        vecs[8] = '{32'd3599,   24'h005959, 1'b0, 1'b0};
        vecs[9] = '{32'd36000,  24'h100000, 1'b0, 1'b0};

        reset       = 1'b1;
        dif.time_in = 32'd0;
        dif.blank   = 1'b0;
        #12;
        chk("rst_digits", {8'b0, dif.digits_bcd}, 32'h0);
        chk("rst_busy", {31'b0, dif.busy}, 32'd0);
        chk("rst_range_err", {31'b0, dif.range_err}, 32'd0);
        chk("rst_an_off", {26'b0, dif.an}, 32'h3F);
        @(negedge clk);
        reset = 1'b0;

        busy_hi = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (dif.busy) busy_hi++;
        end
        chk("idle_no_busy", busy_hi, 0);
        chk("idle_digits", {8'b0, dif.digits_bcd}, 32'h0);
        scan_check("scan_zero", 24'h000000);

        foreach (vecs[i]) begin
            apply($sformatf("vec%0d", i), vecs[i].t, vecs[i].d, vecs[i].re);
            if (vecs[i].scan) scan_check($sformatf("scan%0d", i), vecs[i].d);
        end

        // 61 then 62 while the first conversion is still running
        dif.time_in = 32'd61;
        @(negedge clk);
        chk("chg_busy_rise", {31'b0, dif.busy}, 32'd1);
        dif.time_in = 32'd62;
        prev_d    = dif.digits_bcd;
        first_new = '0;
        illegal   = 0;
        nchg      = 0;
        done      = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (!(dif.digits_bcd inside {24'h100000, 24'h000101, 24'h000102})) illegal++;
            if (dif.digits_bcd != prev_d) begin
                if (nchg == 0) first_new = dif.digits_bcd;
                nchg++;
                prev_d = dif.digits_bcd;
            end
            if (dif.digits_bcd == 24'h000102 && !dif.busy) done = 1'b1;
        end
        chk("chg_done", {31'b0, done}, 32'd1);
        chk("chg_no_torn", illegal, 0);
        chk("chg_first_commit", {8'b0, first_new}, 32'h000101);
        chk("chg_commit_count", nchg, 2);

        // Async reset in the middle of a conversion
        dif.time_in = 32'd86399;
        repeat (3) @(negedge clk);
        chk("mid_busy", {31'b0, dif.busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_digits", {8'b0, dif.digits_bcd}, 32'h0);
        chk("async_rst_busy", {31'b0, dif.busy}, 32'd0);
        chk("async_rst_an", {26'b0, dif.an}, 32'h3F);
        dif.time_in = 32'd7;
        @(negedge clk);
        reset = 1'b0;
        apply("post_rst", 32'd7, 24'h000007, 1'b0);

        // Blanking, then per-digit dwell time
        dif.blank = 1'b1;
        repeat (2) @(negedge clk);
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (dif.an != 6'h3F) bad++;
        end
        chk("blank_an_off", bad, 0);
        chk("blank_digits_kept", {8'b0, dif.digits_bcd}, 32'h000007);
        dif.blank = 1'b0;
        @(negedge clk);
        prev_an = dif.an;
        run     = 1;
        started = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (dif.an == prev_an) begin
                run++;
            end else begin
                if (started) chk("dwell_cycles", run, 4);
                started = 1'b1;
                run     = 1;
                prev_an = dif.an;
            end
        end
        scan_check("scan_odd_so", 24'h000007);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
